sw_pe_affine_p: RTL

- Next-generation Smith-Waterman systolic processing element with affine gap penalties.
- One PE holds one query character `s`. Target characters `t` stream through it, one column per valid cycle. The PE passes H, F, t and the running best score plus its column to the next PE downstream.
- New over the current PE: parametrised widths, runtime-programmable scores, local/global floor mode, saturating signed arithmetic, stall support, row-end handshake, and best-score column tracking.

---
 rtl/sw_pe_affine_p.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sw_pe_affine_p.sv
// rtl/sw_pe_affine_p.sv - Smith-Waterman affine-gap systolic PE with saturating signed scores.
// Optional macro SW_PE_TRACEBACK_EN adds the 2-bit tb_out traceback code.
module sw_pe_affine_p #(
  parameter int SW = 12,
  parameter int CW = 2,
  parameter int IW = 10,
  parameter int PW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PW-1:0]        cfg_match,
  input  logic [PW-1:0]        cfg_mismatch,
  input  logic [PW-1:0]        cfg_open,
  input  logic [PW-1:0]        cfg_extend,
  input  logic                 cfg_local,
  input  logic [CW-1:0]        s_in,
  input  logic [CW-1:0]        t_in,
  input  logic                 valid_in,
  input  logic                 last_in,
  input  logic signed [SW-1:0] v_in,
  input  logic signed [SW-1:0] f_in,
  input  logic signed [SW-1:0] max_in,
  input  logic [IW-1:0]        maxidx_in,
  output logic [CW-1:0]        t_out,
  output logic signed [SW-1:0] v_out,
  output logic signed [SW-1:0] f_out,
  output logic signed [SW-1:0] max_out,
  output logic [IW-1:0]        maxidx_out,
  output logic                 valid_out,
  output logic                 last_out,
`ifdef SW_PE_TRACEBACK_EN
  output logic [1:0]           tb_out,
`endif
  output logic                 busy
);

  localparam logic signed [SW-1:0] MAXV    = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV    = {1'b1, {(SW-1){1'b0}}};
  localparam logic [IW-1:0]        ONE_COL = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_s;
  logic [IW-1:0]         r_col;
  logic signed [SW-1:0]  r_diag, r_hprev, r_eprev, r_best;
  logic [IW-1:0]         r_bcol;

  logic                  w_first;
  logic [CW-1:0]         w_s;
  logic [IW-1:0]         w_col, w_bcol0, w_bcol;
  logic signed [SW-1:0]  w_diag, w_hprev, w_eprev, w_best0, w_best;
  logic signed [SW-1:0]  w_hd, w_e, w_f, w_hmax, w_h;
  logic                  w_up;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  function automatic logic signed [SW-1:0] f_sat(input logic [SW:0] x);
    if (x[SW] != x[SW-1]) return x[SW] ? MINV : MAXV;
    return x[SW-1:0];
  endfunction

  function automatic logic signed [SW-1:0] f_add(input logic signed [SW-1:0] a, input logic [PW-1:0] b);
    return f_sat({a[SW-1], a} + {{(SW+1-PW){1'b0}}, b});
  endfunction

  function automatic logic signed [SW-1:0] f_sub(input logic signed [SW-1:0] a, input logic [PW-1:0] b);
    return f_sat({a[SW-1], a} - {{(SW+1-PW){1'b0}}, b});
  endfunction

  function automatic logic signed [SW-1:0] f_max(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // The first column of a row uses fresh boundaries instead of the held row state.
  assign w_first  = (r_state == IDLE);
  assign w_s      = w_first ? s_in : r_s;
  assign w_col    = w_first ? '0   : r_col;
  assign w_diag   = w_first ? '0   : r_diag;
  assign w_hprev  = w_first ? '0   : r_hprev;
  assign w_eprev  = w_first ? MINV : r_eprev;
  assign w_best0  = w_first ? '0   : r_best;
  assign w_bcol0  = w_first ? '0   : r_bcol;

  assign w_hd   = (w_s == t_in) ? f_add(w_diag, cfg_match) : f_sub(w_diag, cfg_mismatch);
  assign w_e    = f_max(f_sub(w_eprev, cfg_extend), f_sub(w_hprev, cfg_open));
  assign w_f    = f_max(f_sub(f_in, cfg_extend), f_sub(v_in, cfg_open));
  assign w_hmax = f_max(w_hd, f_max(w_e, w_f));
  assign w_h    = (cfg_local && (w_hmax < 0)) ? '0 : w_hmax;

  assign w_best = (w_h > w_best0) ? w_h   : w_best0;
  assign w_bcol = (w_h > w_best0) ? w_col : w_bcol0;
  assign w_up   = (max_in >= w_best);

  assign busy = (r_state == RUN);

  always_comb begin
    w_state_nxt = r_state;
    if (valid_in) w_state_nxt = last_in ? IDLE : RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s        <= '0;
      r_col      <= '0;
      r_diag     <= '0;
      r_hprev    <= '0;
      r_eprev    <= '0;
      r_best     <= '0;
      r_bcol     <= '0;
      t_out      <= '0;
      v_out      <= '0;
      f_out      <= '0;
      max_out    <= '0;
      maxidx_out <= '0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
    end else begin
      valid_out <= valid_in;
      last_out  <= valid_in & last_in;
      if (valid_in) begin
        r_s        <= w_s;
        r_col      <= (w_col == '1) ? w_col : w_col + ONE_COL;
        r_diag     <= v_in;
        r_hprev    <= w_h;
        r_eprev    <= w_e;
        r_best     <= w_best;
        r_bcol     <= w_bcol;
        t_out      <= t_in;
        v_out      <= w_h;
        f_out      <= w_f;
        max_out    <= w_up ? max_in    : w_best;
        maxidx_out <= w_up ? maxidx_in : w_bcol;
      end
    end
  end

`ifdef SW_PE_TRACEBACK_EN
  logic [1:0] w_tb;

  always_comb begin
    w_tb = 2'd0;
    if (cfg_local && (w_hmax < 0)) w_tb = 2'd0;
    else if ((w_hd >= w_e) && (w_hd >= w_f)) w_tb = 2'd1;
    else if (w_e >= w_f) w_tb = 2'd2;
    else w_tb = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           tb_out <= 2'd0;
    else if (valid_in) tb_out <= w_tb;
  end
`endif

endmodule
